// File: rtl/key_ctrl.sv
// key_ctrl: button front-end for the player.
//   Synchronises and debounces five raw buttons, keeps the song index (wrapping) and the
//   volume level (saturating), issues one-cycle strobes for accepted actions, toggles the
//   pause level and auto-repeats volume steps while a volume key stays held.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   i_btn_*          raw asynchronous buttons (next, pre, up, down, pause), active high
//   i_finish_song    one-cycle strobe: current song ended (acts like next)
//   o_next, o_pre    one-cycle strobes: song index moved forward / backward
//   o_vol_plus/dec   one-cycle strobes: volume level actually changed up / down
//   o_pause          pause level
//   o_vol_level      current volume 0..15
//   o_song_idx       current song index 0..NUM_SONGS-1
module key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 15_000_000,
    parameter int unsigned VOL_INIT        = 8,
    parameter int unsigned NUM_SONGS       = 4,
    parameter int unsigned SONG_W          = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_btn_next,
    input  logic              i_btn_pre,
    input  logic              i_btn_up,
    input  logic              i_btn_down,
    input  logic              i_btn_pause,
    input  logic              i_finish_song,
    output logic              o_next,
    output logic              o_pre,
    output logic              o_vol_plus,
    output logic              o_vol_dec,
    output logic              o_pause,
    output logic [3:0]        o_vol_level,
    output logic [SONG_W-1:0] o_song_idx
);

    localparam int unsigned NK      = 5;
    localparam int unsigned K_NEXT  = 0;
    localparam int unsigned K_PRE   = 1;
    localparam int unsigned K_UP    = 2;
    localparam int unsigned K_DOWN  = 3;
    localparam int unsigned K_PAUSE = 4;

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
    localparam int unsigned REP_W = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(NUM_SONGS - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} rep_state_t;

    // ---------------------------------------------------------------- sync + debounce
    logic [NK-1:0]   w_raw;
    logic [NK-1:0]   r_sync1;
    logic [NK-1:0]   r_sync2;
    logic [NK-1:0]   r_stable;
    logic [NK-1:0]   w_rise;
    logic [DB_W-1:0] r_db_cnt [NK];

    assign w_raw = {i_btn_pause, i_btn_down, i_btn_up, i_btn_pre, i_btn_next};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int k = 0; k < NK; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int k = 0; k < NK; k++) begin
                if (r_sync2[k] != r_stable[k]) begin
                    if (r_db_cnt[k] == DB_MAX) begin
                        r_stable[k] <= r_sync2[k];
                        r_db_cnt[k] <= '0;
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                    end
                end else begin
                    r_db_cnt[k] <= '0;
                end
            end
        end
    end

    // Rise is flagged on the same edge that stable flips, so strobes register together with it.
    always_comb begin
        for (int k = 0; k < NK; k++) begin
            w_rise[k] = r_sync2[k] && !r_stable[k] && (r_db_cnt[k] == DB_MAX);
        end
    end

    // ---------------------------------------------------------------- song index
    logic              w_key_next;
    logic              w_key_pre;
    logic              w_inc;
    logic              w_do_inc;
    logic              w_do_dec;
    logic [SONG_W-1:0] r_song_idx;
    logic              r_next;
    logic              r_pre;

    // Simultaneous next/pre key rises cancel each other; finish_song still counts as next.
    always_comb begin
        w_key_next = w_rise[K_NEXT] && !w_rise[K_PRE];
        w_key_pre  = w_rise[K_PRE] && !w_rise[K_NEXT];
        w_inc      = w_key_next || i_finish_song;
        w_do_inc   = w_inc && !w_key_pre;
        w_do_dec   = w_key_pre && !w_inc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_song_idx <= '0;
            r_next     <= 1'b0;
            r_pre      <= 1'b0;
        end else begin
            r_next <= w_do_inc;
            r_pre  <= w_do_dec;
            if (w_do_inc) begin
                r_song_idx <= (r_song_idx == SONG_LAST) ? '0 : r_song_idx + 1'b1;
            end else if (w_do_dec) begin
                r_song_idx <= (r_song_idx == '0) ? SONG_LAST : r_song_idx - 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- volume + repeat FSM
    rep_state_t       r_state;
    rep_state_t       w_state_d;
    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_cnt_d;
    logic             r_rep_up;
    logic             w_rep_up_d;
    logic             w_step_up;
    logic             w_step_dn;
    logic             w_up_only;
    logic             w_dn_only;
    logic             w_held_stable;
    logic             w_both_stable;
    logic             w_period_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_rep_cnt <= '0;
            r_rep_up  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_rep_cnt <= w_rep_cnt_d;
            r_rep_up  <= w_rep_up_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_rep_cnt_d   = r_rep_cnt;
        w_rep_up_d    = r_rep_up;
        w_step_up     = 1'b0;
        w_step_dn     = 1'b0;
        w_up_only     = w_rise[K_UP] && !w_rise[K_DOWN];
        w_dn_only     = w_rise[K_DOWN] && !w_rise[K_UP];
        w_held_stable = r_rep_up ? r_stable[K_UP] : r_stable[K_DOWN];
        w_both_stable = r_stable[K_UP] && r_stable[K_DOWN];
        w_period_done = (r_state == StHold) ? (r_rep_cnt == DELAY_LAST)
                                            : (r_rep_cnt == PERIOD_LAST);

        if (w_up_only || w_dn_only) begin
            // A fresh press always (re)starts the hold timer for that direction.
            w_step_up   = w_up_only;
            w_step_dn   = w_dn_only;
            w_state_d   = StHold;
            w_rep_cnt_d = '0;
            w_rep_up_d  = w_up_only;
        end else if (w_rise[K_UP] && w_rise[K_DOWN]) begin
            w_state_d   = StIdle;
            w_rep_cnt_d = '0;
        end else begin
            case (r_state)
                StHold, StRepeat: begin
                    if (!w_held_stable || w_both_stable) begin
                        w_state_d   = StIdle;
                        w_rep_cnt_d = '0;
                    end else if (w_period_done) begin
                        w_state_d   = StRepeat;
                        w_rep_cnt_d = '0;
                        w_step_up   = r_rep_up;
                        w_step_dn   = !r_rep_up;
                    end else begin
                        w_rep_cnt_d = r_rep_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_d   = StIdle;
                    w_rep_cnt_d = '0;
                end
            endcase
        end
    end

    logic [3:0] r_vol;
    logic       r_vol_plus;
    logic       r_vol_dec;
    logic       r_pause;

    // Steps at the limits hold the level and suppress the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vol      <= 4'(VOL_INIT);
            r_vol_plus <= 1'b0;
            r_vol_dec  <= 1'b0;
            r_pause    <= 1'b0;
        end else begin
            r_vol_plus <= 1'b0;
            r_vol_dec  <= 1'b0;
            r_pause    <= r_pause ^ w_rise[K_PAUSE];
            if (w_step_up && (r_vol != 4'hF)) begin
                r_vol      <= r_vol + 1'b1;
                r_vol_plus <= 1'b1;
            end else if (w_step_dn && (r_vol != 4'h0)) begin
                r_vol     <= r_vol - 1'b1;
                r_vol_dec <= 1'b1;
            end
        end
    end

    assign o_next      = r_next;
    assign o_pre       = r_pre;
    assign o_vol_plus  = r_vol_plus;
    assign o_vol_dec   = r_vol_dec;
    assign o_pause     = r_pause;
    assign o_vol_level = r_vol;
    assign o_song_idx  = r_song_idx;

endmodule
